// File: rtl/puf_session_if.sv
// -----------------------------------------------------------------------------
// puf_session_if
//   Handshake/control bundle between the PUF session sequencer and the UART /
//   PUF / response-FIFO data path.
//
//   master : the sequencer (puf_session_ctrl)
//   slave  : the data path (UART rx/tx, PUF core, response FIFO, tx mux)
//
//   rx_valid        dp -> ctrl  new rx byte pulse (byte held until next pulse)
//   id_requested    dp -> ctrl  current rx byte equals the request ID
//   tx_start        ctrl -> dp  UART tx latches its data input
//   tx_done         dp -> ctrl  UART tx finished the byte
//   data_sel        ctrl -> dp  tx mux: 0 = ID, 1 = FIFO output
//   store_challenge ctrl -> dp  challenge register load enable
//   puf_start       ctrl -> dp  PUF evaluates the stored challenge
//   puf_done        dp -> ctrl  PUF responses written to the FIFO
//   fifo_empty      dp -> ctrl  response FIFO empty
//   fifo_rd_en      ctrl -> dp  FIFO pop, data valid the following cycle
//   busy            ctrl -> dp  sequencer not idle
//   err_timeout     ctrl -> dp  PUF did not finish in time
//   rx_dropped      ctrl -> dp  rx byte arrived while it could not be used
// -----------------------------------------------------------------------------
interface puf_session_if;
  logic rx_valid;
  logic id_requested;
  logic tx_start;
  logic tx_done;
  logic data_sel;
  logic store_challenge;
  logic puf_start;
  logic puf_done;
  logic fifo_empty;
  logic fifo_rd_en;
  logic busy;
  logic err_timeout;
  logic rx_dropped;

  modport master (
    input  rx_valid, id_requested, tx_done, puf_done, fifo_empty,
    output tx_start, data_sel, store_challenge, puf_start, fifo_rd_en,
           busy, err_timeout, rx_dropped
  );

  modport slave (
    output rx_valid, id_requested, tx_done, puf_done, fifo_empty,
    input  tx_start, data_sel, store_challenge, puf_start, fifo_rd_en,
           busy, err_timeout, rx_dropped
  );
endinterface

// File: rtl/puf_session_ctrl.sv
// -----------------------------------------------------------------------------
// puf_session_ctrl
//   Session sequencer for the PUF UART data path. Waits for an ID request on
//   the rx byte stream, returns the ID, takes the next byte as a challenge,
//   runs the PUF with a timeout, then streams N_RESPONSES bytes from the
//   response FIFO to UART tx.
//
//   Ports
//     clk    global clock
//     reset  synchronous, active-high; aborts any session immediately
//     bus    puf_session_if.master, see the interface header for signals
//
//   Every output is a register. Each strobe is high during the first cycle
//   of the state that owns it (tx_start for responses is the exception: it
//   sits one cycle after the FIFO pop so the FIFO output is valid).
// -----------------------------------------------------------------------------
module puf_session_ctrl #(
  parameter int N_RESPONSES = 4,     // 1..255
  parameter int PUF_TIMEOUT = 1024,  // >= 2
  parameter int CNT_W       = 16     // 2**CNT_W > PUF_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset,
  puf_session_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SEND_ID,
    S_WAIT_ID_TX,
    S_WAIT_CHAL,
    S_CAPTURE,
    S_START,
    S_RUN,
    S_DRAIN_POP,
    S_DRAIN_TX,
    S_WAIT_RESP_TX
  } state_e;

  // RUN gives up when the incremented count hits this value, so the PUF gets
  // PUF_TIMEOUT-1 RUN cycles and err_timeout lands PUF_TIMEOUT cycles after
  // puf_start.
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(PUF_TIMEOUT - 1);
  localparam logic [8:0]       N_RESP9   = 9'(N_RESPONSES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]       resp_cnt_q, resp_cnt_d;

  logic tx_start_q,        tx_start_d;
  logic data_sel_q,        data_sel_d;
  logic store_challenge_q, store_challenge_d;
  logic puf_start_q,       puf_start_d;
  logic fifo_rd_en_q,      fifo_rd_en_d;
  logic busy_q,            busy_d;
  logic err_timeout_q,     err_timeout_d;
  logic rx_dropped_q,      rx_dropped_d;

  // ---------------------------------------------------------------------------
  // Next state, counters and next output values
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    tmo_cnt_d     = tmo_cnt_q;
    resp_cnt_d    = resp_cnt_q;
    err_timeout_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Non-ID bytes in IDLE are simply not for us; they are not "dropped".
        if (bus.rx_valid && bus.id_requested) state_d = S_SEND_ID;
      end

      S_SEND_ID:    state_d = S_WAIT_ID_TX;

      S_WAIT_ID_TX: if (bus.tx_done) state_d = S_WAIT_CHAL;

      // Any byte is a challenge here, even one equal to the request ID.
      S_WAIT_CHAL:  if (bus.rx_valid) state_d = S_CAPTURE;

      S_CAPTURE:    state_d = S_START;

      S_START: begin
        tmo_cnt_d = '0;
        state_d   = S_RUN;
      end

      S_RUN: begin
        // puf_done takes priority over a timeout in the same cycle.
        if (bus.puf_done) begin
          resp_cnt_d = '0;
          state_d    = S_DRAIN_POP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          if (tmo_cnt_d == TMO_LIMIT) begin
            err_timeout_d = 1'b1;
            state_d       = S_IDLE;
          end
        end
      end

      // Never pop an empty FIFO; wait as long as it takes.
      S_DRAIN_POP:  if (!bus.fifo_empty) state_d = S_DRAIN_TX;

      S_DRAIN_TX:   state_d = S_WAIT_RESP_TX;

      S_WAIT_RESP_TX: begin
        if (bus.tx_done) begin
          if (({1'b0, resp_cnt_q} + 9'd1) == N_RESP9) begin
            state_d = S_IDLE;
          end else begin
            resp_cnt_d = resp_cnt_q + 8'd1;
            state_d    = S_DRAIN_POP;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Moore-style strobes keyed on the state being entered.
    tx_start_d        = (state_d == S_SEND_ID) || (state_q == S_DRAIN_TX);
    store_challenge_d = (state_d == S_CAPTURE);
    puf_start_d       = (state_d == S_START);
    fifo_rd_en_d      = (state_d == S_DRAIN_TX);
    data_sel_d        = (state_d inside {S_DRAIN_POP, S_DRAIN_TX, S_WAIT_RESP_TX});
    busy_d            = (state_d != S_IDLE);

    // Only IDLE and WAIT_CHAL consume rx bytes; anywhere else they are lost.
    rx_dropped_d      = bus.rx_valid && !(state_q inside {S_IDLE, S_WAIT_CHAL});
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= S_IDLE;
      tmo_cnt_q         <= '0;
      resp_cnt_q        <= '0;
      tx_start_q        <= 1'b0;
      data_sel_q        <= 1'b0;
      store_challenge_q <= 1'b0;
      puf_start_q       <= 1'b0;
      fifo_rd_en_q      <= 1'b0;
      busy_q            <= 1'b0;
      err_timeout_q     <= 1'b0;
      rx_dropped_q      <= 1'b0;
    end else begin
      state_q           <= state_d;
      tmo_cnt_q         <= tmo_cnt_d;
      resp_cnt_q        <= resp_cnt_d;
      tx_start_q        <= tx_start_d;
      data_sel_q        <= data_sel_d;
      store_challenge_q <= store_challenge_d;
      puf_start_q       <= puf_start_d;
      fifo_rd_en_q      <= fifo_rd_en_d;
      busy_q            <= busy_d;
      err_timeout_q     <= err_timeout_d;
      rx_dropped_q      <= rx_dropped_d;
    end
  end

  assign bus.tx_start        = tx_start_q;
  assign bus.data_sel        = data_sel_q;
  assign bus.store_challenge = store_challenge_q;
  assign bus.puf_start       = puf_start_q;
  assign bus.fifo_rd_en      = fifo_rd_en_q;
  assign bus.busy            = busy_q;
  assign bus.err_timeout     = err_timeout_q;
  assign bus.rx_dropped      = rx_dropped_q;

endmodule

// File: tb/tb_puf_session_ctrl.sv
// -----------------------------------------------------------------------------
// tb_puf_session_ctrl
//   Drives whole sessions as the UART / PUF / FIFO side and checks pulse
//   counts and cycle latencies derived from the session rules. Inputs change
//   1 time unit after the rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_puf_session_ctrl;
  localparam int N_RESP = 4;
  localparam int TMO    = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  puf_session_if bus();

  puf_session_ctrl #(
    .N_RESPONSES(N_RESP),
    .PUF_TIMEOUT(TMO),
    .CNT_W      (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pulse monitor.
  int n_txs = 0, n_txs_sel1 = 0, n_store = 0, n_pst = 0;
  int n_rd = 0, n_err = 0, n_drop = 0;

  always @(negedge clk) begin
    if (bus.tx_start === 1'b1) begin
      n_txs++;
      if (bus.data_sel === 1'b1) n_txs_sel1++;
    end
    if (bus.store_challenge === 1'b1) n_store++;
    if (bus.puf_start === 1'b1)       n_pst++;
    if (bus.fifo_rd_en === 1'b1)      n_rd++;
    if (bus.err_timeout === 1'b1)     n_err++;
    if (bus.rx_dropped === 1'b1)      n_drop++;
  end

  function automatic logic [7:0] outs();
    return {bus.tx_start, bus.data_sel, bus.store_challenge, bus.puf_start,
            bus.fifo_rd_en, bus.busy, bus.err_timeout, bus.rx_dropped};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rx_valid = 1'b0;
    bus.tx_done  = 1'b0;
    bus.puf_done = 1'b0;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return bus.tx_start;
      1:       return bus.puf_start;
      2:       return bus.fifo_rd_en;
      default: return bus.store_challenge;
    endcase
  endfunction

  // Advance cycle by cycle until the selected strobe is seen; lat = cycles
  // waited, -1 if the bound expires.
  task automatic wait_pulse(input int which, input int lim, output int lat);
    lat = -1;
    for (int i = 1; i <= lim; i++) begin
      step();
      idle_inputs();
      @(negedge clk);
      if (sig(which) === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  // One full session.
  //   pdel       cycles from puf_start to puf_done (> TMO-1 means timeout)
  //   stall_idx  response index preceded by a FIFO-empty stall (none if >= N)
  //   drop_run   inject a stray rx byte while the PUF runs
  //   drop_idx   response index during whose tx a stray rx byte is injected
  //   abort_idx  response index after whose tx_start reset is asserted
  task automatic session(input int pdel, input int stall_idx, input int stall_len,
                         input bit drop_run, input int drop_idx, input int abort_idx);
    int  lat, exp_drop, kdrop, err_k, nr, fifo_left, d, kmax;
    int  b_txs, b_sel1, b_store, b_pst, b_rd, b_err, b_drop;
    bit  tmo, sel_ok;
    exp_drop = 0;
    err_k    = -1;
    sel_ok   = 1'b1;
    b_txs = n_txs; b_sel1 = n_txs_sel1; b_store = n_store; b_pst = n_pst;
    b_rd = n_rd; b_err = n_err; b_drop = n_drop;
    bus.fifo_empty = 1'b1;

    // A non-ID byte in IDLE must be ignored silently.
    step(); idle_inputs();
    bus.rx_valid = 1'b1; bus.id_requested = 1'b0;
    step(); idle_inputs();
    @(negedge clk);
    chk("idle_nonid_busy", bus.busy, 1'b0);

    // ID request.
    step(); idle_inputs();
    bus.rx_valid = 1'b1; bus.id_requested = 1'b1;
    wait_pulse(0, 4, lat);
    chk("id_tx_lat", lat, 1);
    chk("id_sel", bus.data_sel, 1'b0);
    chk("id_busy", bus.busy, 1'b1);
    repeat ($urandom_range(0, 3)) begin step(); idle_inputs(); end
    step(); bus.tx_done = 1'b1;
    step(); idle_inputs();
    step();
    @(negedge clk);
    chk("chal_wait_busy", bus.busy, 1'b1);
    chk("chal_wait_store", n_store - b_store, 0);

    // Challenge byte: any value is accepted, including the ID itself.
    step();
    bus.rx_valid = 1'b1; bus.id_requested = 1'($urandom_range(0, 1));
    wait_pulse(3, 3, lat);
    chk("store_lat", lat, 1);
    wait_pulse(1, 3, lat);
    chk("pstart_lat", lat, 1);

    // PUF run.
    tmo   = (pdel > TMO - 1);
    kmax  = (pdel < TMO - 1) ? pdel : TMO - 1;
    kdrop = drop_run ? $urandom_range(1, kmax) : 0;
    for (int k = 1; k <= TMO + 3; k++) begin
      step(); idle_inputs();
      if (k == pdel) bus.puf_done = 1'b1;
      if (k == kdrop) begin
        bus.rx_valid = 1'b1; bus.id_requested = 1'($urandom_range(0, 1));
        exp_drop++;
      end
      @(negedge clk);
      if (bus.err_timeout === 1'b1 && err_k < 0) err_k = k;
      if (!tmo && k == pdel) break;
    end

    if (tmo) begin
      step(); idle_inputs();
      @(negedge clk);
      chk("tmo_at", err_k, TMO);
      chk("tmo_busy", bus.busy, 1'b0);
      chk("tmo_err_cnt", n_err - b_err, 1);
      chk("tmo_rd_cnt", n_rd - b_rd, 0);
      chk("tmo_tx_cnt", n_txs - b_txs, 1);
      chk("tmo_drop_cnt", n_drop - b_drop, exp_drop);
      return;
    end
    chk("done_no_err", err_k, -1);

    // Drain: the FIFO is filled when puf_done is reported.
    fifo_left      = N_RESP;
    bus.fifo_empty = 1'b0;
    for (int i = 0; i < N_RESP; i++) begin
      if (i == stall_idx) begin
        bus.fifo_empty = 1'b1;
        nr = 0;
        for (int s = 0; s < stall_len; s++) begin
          step(); idle_inputs();
          @(negedge clk);
          if (bus.fifo_rd_en === 1'b1) nr++;
        end
        chk("stall_no_pop", nr, 0);
        step(); idle_inputs();
        bus.fifo_empty = 1'b0;
        wait_pulse(2, 4, lat);
        chk("resume_lat", lat, 1);
      end else begin
        wait_pulse(2, 4, lat);
        chk("pop_lat", lat, 2);
      end
      fifo_left--;
      bus.fifo_empty = (fifo_left == 0);

      wait_pulse(0, 1, lat);
      chk("resp_tx_lat", lat, 1);
      chk("resp_sel", bus.data_sel, 1'b1);

      if (i == abort_idx) begin
        step(); idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("abort_outs", outs(), 8'h00);
        return;
      end

      d = $urandom_range(1, 4);
      for (int w = 0; w < d; w++) begin
        step(); idle_inputs();
        if (i == drop_idx && w == 0) begin
          // Stray byte and a stray puf_done: both must be ignored.
          bus.rx_valid = 1'b1; bus.id_requested = 1'($urandom_range(0, 1));
          bus.puf_done = 1'b1;
          exp_drop++;
        end
        @(negedge clk);
        if (bus.data_sel !== 1'b1) sel_ok = 1'b0;
      end
      step(); idle_inputs();
      bus.tx_done = 1'b1;
      @(negedge clk);
    end

    step(); idle_inputs();
    @(negedge clk);
    chk("end_busy", bus.busy, 1'b0);
    chk("end_sel", bus.data_sel, 1'b0);
    chk("sel_held", sel_ok, 1'b1);
    chk("n_store", n_store - b_store, 1);
    chk("n_pstart", n_pst - b_pst, 1);
    chk("n_pop", n_rd - b_rd, N_RESP);
    chk("n_txstart", n_txs - b_txs, 1 + N_RESP);
    chk("n_tx_sel1", n_txs_sel1 - b_sel1, N_RESP);
    chk("n_err", n_err - b_err, 0);
    chk("n_drop", n_drop - b_drop, exp_drop);
  endtask

  initial begin
    bus.rx_valid     = 1'b0;
    bus.id_requested = 1'b0;
    bus.tx_done      = 1'b0;
    bus.puf_done     = 1'b0;
    bus.fifo_empty   = 1'b1;
    reset            = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("reset_outs", outs(), 8'h00);
    step();
    reset = 1'b0;

    session(10, N_RESP, 0, 1'b0, N_RESP, -1);     // plain full session
    session(10, 2, 20, 1'b0, N_RESP, -1);         // FIFO stall before 3rd byte
    session(TMO + 5, N_RESP, 0, 1'b0, N_RESP, -1);// no puf_done at all
    session(8, N_RESP, 0, 1'b1, 1, -1);           // drops in RUN and WAIT_RESP_TX
    session(TMO - 1, N_RESP, 0, 1'b1, N_RESP, -1);// done on the last cycle wins
    session(TMO, N_RESP, 0, 1'b0, N_RESP, -1);    // done one cycle too late
    session(5, N_RESP, 0, 1'b0, N_RESP, 1);       // reset in WAIT_RESP_TX
    session(6, N_RESP, 0, 1'b0, N_RESP, -1);      // clean restart after reset

    for (int r = 0; r < 10; r++) begin
      session($urandom_range(1, TMO + 4), $urandom_range(0, N_RESP),
              $urandom_range(1, 6), 1'($urandom_range(0, 1)),
              $urandom_range(0, N_RESP), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the flow ever desynchronises badly.
  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1);
  end
endmodule
